// File: rtl/regbank_pkg.sv
// Purpose : shared sizing, request struct and address decode for the register-bank write path.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: DATA_W, NUM_REGS, ADDR_W, wr_req_t {addr, data}, onehot_decode(addr).
package regbank_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 3;

   // One requester's write: target register index plus data.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   // Register index to bank load line. An index past the last register
   // yields all zeros, so such a write is silently dropped.
   function automatic logic [NUM_REGS-1:0] onehot_decode(input logic [ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] v;
      v = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (int'(addr) == r) v[r] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Purpose : round-robin arbiter, search starts at the pointer and wraps upward.
// Latency : grant is combinational; pointer moves at the edge of a grant.
// Backpr. : en=0 suppresses every grant and freezes the pointer.
// Ports   : clk, reset (sync, active-high), req[NUM_REQ], en -> gnt (one-hot), gnt_idx.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         gnt_idx
);

   logic [1:0] ptr;
   logic       found;

   // Outer loop walks priority order (ptr, ptr+1, ...), inner loop finds the
   // requester sitting at that rank; the first valid one wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
               found   = 1'b1;
               gnt[i]  = en;
               gnt_idx = 2'(i);
            end
         end
      end
   end

   // The winner drops to lowest priority; without a grant the order is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (|gnt) begin
         ptr <= 2'((int'(gnt_idx) + 1) % NUM_REQ);
      end
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Purpose : shares the single write port of the register bank among NUM_REQ requesters.
// Latency : ready is combinational; reg_load/reg_wdata/grant_id follow one edge after the handshake.
// Backpr. : stall or reset holds every req_ready low; at most one write is accepted per cycle.
// Ports   : clk, reset, stall, req_valid/req_addr/req_data (packed per requester) -> req_ready,
//           reg_load (one-hot), reg_wdata, grant_id, busy.
module regbank_write_arbiter
   import regbank_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REGS-1:0]       reg_load,
   output logic [DATA_W-1:0]         reg_wdata,
   output logic [1:0]                grant_id,
   output logic                      busy
);

   logic [NUM_REQ-1:0] gnt;
   logic [1:0]         gnt_idx;
   logic               transfer;
   wr_req_t            sel;

   // Reset also gates the grant so nothing is accepted while the bench of
   // requesters is being cleared.
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .en      (~stall & ~reset),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign transfer  = |gnt;

   // One-hot mux of the granted requester's address and data.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel.addr = req_addr[i*ADDR_W +: ADDR_W];
            sel.data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Load lines pulse for exactly one cycle per accepted write; wdata keeps
   // its last value between writes. busy flags any valid requester that was
   // left waiting this cycle (lost arbitration or stalled).
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_load  <= '0;
         reg_wdata <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         busy <= |(req_valid & ~gnt);
         if (transfer) begin
            reg_load  <= onehot_decode(sel.addr);
            reg_wdata <= sel.data;
            grant_id  <= gnt_idx;
         end else begin
            reg_load  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
module tb_regbank_write_arbiter;
   import regbank_pkg::*;

   localparam int NREQ = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   stall;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic [NUM_REGS-1:0]    reg_load;
   logic [DATA_W-1:0]      reg_wdata;
   logic [1:0]             grant_id;
   logic                   busy;

   regbank_write_arbiter #(.NUM_REQ(NREQ)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .reg_load  (reg_load),
      .reg_wdata (reg_wdata),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_REGS-1:0] load;
      logic [DATA_W-1:0]   data;
      logic [1:0]          id;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        exp_busy = 1'b0;
   logic [15:0] bank [NUM_REGS];

   // Behavioural register bank: no reset, captures on its load line.
   always @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (reg_load[r]) bank[r] <= reg_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every load pulse must match the oldest outstanding expected write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reg_load !== '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_load", 32'(reg_load), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("reg_load", 32'(reg_load), 32'(e.load));
               chk("reg_wdata", 32'(reg_wdata), 32'(e.data));
               chk("grant_id", 32'(grant_id), 32'(e.id));
            end
         end
      end
   end

   // One cycle of stimulus; exp_rdy is the hand-derived grant for this cycle.
   task automatic step(input logic [1:0] v, input logic [2:0] a0, input logic [2:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic st,
                       input logic [1:0] exp_rdy);
      exp_t e;
      req_valid = v;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      stall     = st;
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      exp_busy = reset ? 1'b0 : |(v & ~exp_rdy);
      if (exp_rdy[0]) begin
         e.load = NUM_REGS'(1) << a0; e.data = d0; e.id = 2'd0;
         exp_q.push_back(e);
      end else if (exp_rdy[1]) begin
         e.load = NUM_REGS'(1) << a1; e.data = d1; e.id = 2'd1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      @(posedge clk); #1;

      // Reset: valid requests must not be granted.
      step(2'b11, 3'd1, 3'd2, 16'h1234, 16'h5678, 1'b0, 2'b00);
      step(2'b11, 3'd1, 3'd2, 16'h1234, 16'h5678, 1'b0, 2'b00);
      reset = 1'b0;
      chk("rst_reg_load", 32'(reg_load), 32'h0);
      chk("rst_reg_wdata", 32'(reg_wdata), 32'h0);
      chk("rst_grant_id", 32'(grant_id), 32'h0);
      step(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 2'b00);

      // Single write from requester 0 (pointer 0 -> 1).
      step(2'b01, 3'd3, 3'd0, 16'hA5A5, 16'h0, 1'b0, 2'b01);
      step(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 2'b00);
      chk("bank_r3_single", 32'(bank[3]), 32'hA5A5);

      // Same-address conflict with pointer 1: requester 1 first, requester 0 last.
      step(2'b11, 3'd5, 3'd5, 16'h1111, 16'h2222, 1'b0, 2'b10);
      step(2'b01, 3'd5, 3'd5, 16'h1111, 16'h2222, 1'b0, 2'b01);
      // Requester 1 alone, bringing the pointer back to 0.
      step(2'b10, 3'd0, 3'd7, 16'h0, 16'hBEEF, 1'b0, 2'b10);

      // Contention from pointer 0: grants alternate 0,1,0,1.
      step(2'b11, 3'd1, 3'd2, 16'h0101, 16'h0202, 1'b0, 2'b01);
      step(2'b11, 3'd1, 3'd2, 16'h0101, 16'h0202, 1'b0, 2'b10);
      step(2'b11, 3'd1, 3'd2, 16'h0101, 16'h0202, 1'b0, 2'b01);
      step(2'b11, 3'd1, 3'd2, 16'h0101, 16'h0202, 1'b0, 2'b10);

      // Move the pointer to 1, then stall with both valid for 3 cycles.
      step(2'b01, 3'd0, 3'd0, 16'h0C0C, 16'h0, 1'b0, 2'b01);
      step(2'b11, 3'd4, 3'd0, 16'h4444, 16'h5555, 1'b1, 2'b00);
      step(2'b11, 3'd4, 3'd0, 16'h4444, 16'h5555, 1'b1, 2'b00);
      step(2'b11, 3'd4, 3'd0, 16'h4444, 16'h5555, 1'b1, 2'b00);
      step(2'b11, 3'd4, 3'd0, 16'h4444, 16'h5555, 1'b0, 2'b10);
      step(2'b01, 3'd4, 3'd0, 16'h4444, 16'h5555, 1'b0, 2'b01);

      // Reset right after a transfer to r6 (pointer would be 1 without reset).
      step(2'b01, 3'd6, 3'd0, 16'h6666, 16'h0, 1'b0, 2'b01);
      reset = 1'b1;
      step(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 2'b00);
      reset = 1'b0;
      chk("midrst_reg_load", 32'(reg_load), 32'h0);
      chk("midrst_reg_wdata", 32'(reg_wdata), 32'h0);
      chk("midrst_grant_id", 32'(grant_id), 32'h0);
      chk("midrst_bank_r6", 32'(bank[6]), 32'h6666);
      step(2'b11, 3'd2, 3'd3, 16'h2222, 16'h3333, 1'b0, 2'b01);
      step(2'b10, 3'd2, 3'd3, 16'h2222, 16'h3333, 1'b0, 2'b10);
      step(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 2'b00);
      step(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 2'b00);

      // Final bank image.
      chk("bank_r0", 32'(bank[0]), 32'h5555);
      chk("bank_r1", 32'(bank[1]), 32'h0101);
      chk("bank_r2", 32'(bank[2]), 32'h2222);
      chk("bank_r3", 32'(bank[3]), 32'h3333);
      chk("bank_r4", 32'(bank[4]), 32'h4444);
      chk("bank_r5", 32'(bank[5]), 32'h1111);
      chk("bank_r6", 32'(bank[6]), 32'h6666);
      chk("bank_r7", 32'(bank[7]), 32'hBEEF);
      chk("pending_writes", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
